// File: rtl/face_frame_scheduler.sv
// face_frame_scheduler: buffers 162-bit cube orientations from the SPI receiver
// and feeds the six 27-bit faces, one at a time, to the WS2812B stream engine.
// After the last face the line is held low for the latch gap, then frame_done
// pulses. An idle held frame is periodically re-sent to recover from glitches.
module face_frame_scheduler #(
    parameter int NUM_FACES      = 6,
    parameter int LATCH_CYCLES   = 2000,
    parameter int REFRESH_CYCLES = 4000000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     orient_valid,
    input  logic [27*NUM_FACES-1:0]  orient_in,
    input  logic                     face_done,
    output logic                     face_start,
    output logic [2:0]               face_sel,
    output logic [26:0]              face_orient,
    output logic                     latch_active,
    output logic                     frame_done,
    output logic                     busy,
    output logic                     pending,
    output logic [7:0]               drop_count
);
    localparam logic [2:0]  LAST_FACE    = 3'(NUM_FACES - 1);
    localparam logic [15:0] LATCH_LAST   = 16'(LATCH_CYCLES - 1);
    localparam bit          REFRESH_EN   = (REFRESH_CYCLES != 0);
    localparam logic [23:0] REFRESH_LAST = REFRESH_EN ? 24'(REFRESH_CYCLES - 1) : 24'd0;

    typedef enum logic [1:0] {IDLE, START, WAIT, LATCH} state_t;
    state_t state, state_nxt;

    logic [NUM_FACES-1:0][26:0] pend_buf;
    logic [NUM_FACES-1:0][26:0] active;
    logic                       have_frame;
    logic [15:0]                latch_cnt;
    logic [23:0]                refresh_cnt;
    logic                       take_pending;
    logic                       refresh_due;

    // Pending data always beats a refresh expiring in the same cycle.
    assign take_pending = (state == IDLE) && pending;
    assign refresh_due  = REFRESH_EN && (state == IDLE) && have_frame && !pending &&
                          (refresh_cnt == REFRESH_LAST);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take_pending || refresh_due) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (face_done) state_nxt = (face_sel == LAST_FACE) ? LATCH : START;
            LATCH:   if (latch_cnt == LATCH_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from registered state; face slice muxed from the active frame.
    always_comb begin
        face_start   = (state == START);
        busy         = (state != IDLE);
        latch_active = (state == LATCH);
        face_orient  = '0;
        for (int k = 0; k < NUM_FACES; k++)
            if (face_sel == 3'(k)) face_orient = active[k];
    end

    // frame_done pulses in the first IDLE cycle after the latch gap.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) frame_done <= 1'b0;
        else          frame_done <= (state == LATCH) && (state_nxt == IDLE);
    end

    // Face index: rewound when a frame starts, advanced on each non-final face_done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            face_sel <= '0;
        else if (state == IDLE && state_nxt == START)
            face_sel <= '0;
        else if (state == WAIT && face_done && face_sel != LAST_FACE)
            face_sel <= face_sel + 3'd1;
    end

    // Latch gap counter runs only in LATCH and is zero on entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)              latch_cnt <= '0;
        else if (state == LATCH)   latch_cnt <= latch_cnt + 16'd1;
        else                       latch_cnt <= '0;
    end

    // Refresh timer counts idle cycles while a frame is held; cleared on leaving IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            refresh_cnt <= '0;
        else if (state == IDLE && have_frame && state_nxt == IDLE)
            refresh_cnt <= refresh_cnt + 24'd1;
        else
            refresh_cnt <= '0;
    end

    // Pending buffer: latest write wins; an overwrite of unsent data counts a drop,
    // except when IDLE consumes the old value in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_buf   <= '0;
            pending    <= 1'b0;
            drop_count <= '0;
        end else if (orient_valid) begin
            pend_buf <= orient_in;
            pending  <= 1'b1;
            if (pending && !take_pending && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
        end else if (take_pending) begin
            pending <= 1'b0;
        end
    end

    // Active frame only loads from IDLE, so it is frozen while busy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active     <= '0;
            have_frame <= 1'b0;
        end else if (take_pending) begin
            active     <= pend_buf;
            have_frame <= 1'b1;
        end
    end

endmodule

// File: tb/tb_face_frame_scheduler.sv
// Bench for face_frame_scheduler: scoreboard of expected face starts
// (cycle, index, slice) checked against starts observed from the DUT.
module tb_face_frame_scheduler;
    localparam int NF = 6;
    localparam int LC = 4;
    localparam int RC = 20;
    localparam int ENG = 10;
    localparam int FRAME_LEN = 2 + 11 * (NF - 1) + ENG + LC + 1;  // drive cycle -> frame_done

    typedef struct {
        int         cyc;
        logic [2:0] sel;
        logic [26:0] orient;
    } ev_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         orient_valid = 1'b0;
    logic [161:0] orient_in = '0;
    logic         spur = 1'b0;
    logic         eng_done, z_eng_done;
    logic         face_done, z_face_done;

    logic         face_start, latch_active, frame_done, busy, pending;
    logic [2:0]   face_sel;
    logic [26:0]  face_orient;
    logic [7:0]   drop_count;
    logic         z_face_start, z_latch_active, z_frame_done, z_busy, z_pending;
    logic [2:0]   z_face_sel;
    logic [26:0]  z_face_orient;
    logic [7:0]   z_drop_count;

    int vec = 0;
    int miss = 0;
    int cyc = 0;
    int latch_n = 0;
    int z_starts = 0;
    ev_t st_q[$];
    ev_t exp_q[$];
    int  fd_q[$];
    ev_t mon_ev;

    always #5 clk = ~clk;

    assign face_done   = eng_done | spur;
    assign z_face_done = z_eng_done;

    face_frame_scheduler #(.NUM_FACES(NF), .LATCH_CYCLES(LC), .REFRESH_CYCLES(RC)) dut (
        .clk(clk), .reset_n(reset_n), .orient_valid(orient_valid), .orient_in(orient_in),
        .face_done(face_done), .face_start(face_start), .face_sel(face_sel),
        .face_orient(face_orient), .latch_active(latch_active), .frame_done(frame_done),
        .busy(busy), .pending(pending), .drop_count(drop_count));

    face_frame_scheduler #(.NUM_FACES(NF), .LATCH_CYCLES(LC), .REFRESH_CYCLES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .orient_valid(orient_valid), .orient_in(orient_in),
        .face_done(z_face_done), .face_start(z_face_start), .face_sel(z_face_sel),
        .face_orient(z_face_orient), .latch_active(z_latch_active), .frame_done(z_frame_done),
        .busy(z_busy), .pending(z_pending), .drop_count(z_drop_count));

    // Stream engine model: face_done ENG cycles after each face_start.
    int eng_cnt, z_eng_cnt;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            eng_cnt <= 0; eng_done <= 1'b0;
        end else begin
            eng_done <= 1'b0;
            if (face_start) eng_cnt <= ENG - 1;
            else if (eng_cnt != 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1) eng_done <= 1'b1;
            end
        end
    end
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            z_eng_cnt <= 0; z_eng_done <= 1'b0;
        end else begin
            z_eng_done <= 1'b0;
            if (z_face_start) z_eng_cnt <= ENG - 1;
            else if (z_eng_cnt != 0) begin
                z_eng_cnt <= z_eng_cnt - 1;
                if (z_eng_cnt == 1) z_eng_done <= 1'b1;
            end
        end
    end

    // Cycle counter and output monitor.
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (face_start) begin
            mon_ev.cyc = cyc; mon_ev.sel = face_sel; mon_ev.orient = face_orient;
            st_q.push_back(mon_ev);
        end
        if (frame_done)   fd_q.push_back(cyc);
        if (latch_active) latch_n <= latch_n + 1;
        if (z_face_start) z_starts <= z_starts + 1;
    end

    task automatic tick();
        @(negedge clk); #1;
    endtask

    task automatic do_reset();
        orient_valid = 1'b0; spur = 1'b0; reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    function automatic logic [161:0] mk_frame(input logic [26:0] base);
        logic [161:0] f;
        f = '0;
        for (int k = 0; k < NF; k++) f[27*k +: 27] = base + 27'(k);
        return f;
    endfunction

    // Drive a one-cycle orient_valid; n is the cycle it is high in.
    task automatic drive_frame(input logic [161:0] f, output int n);
        orient_valid = 1'b1; orient_in = f; n = cyc;
        tick();
        orient_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [161:0] f, input int first);
        ev_t e;
        for (int k = 0; k < NF; k++) begin
            e.cyc = first + 11 * k; e.sel = 3'(k); e.orient = f[27*k +: 27];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_starts(input int n, input int budget, output bit ok);
        int b;
        b = 0;
        while (st_q.size() < n && b < budget) begin tick(); b++; end
        ok = (st_q.size() >= n);
    endtask

    task automatic wait_fd(input int n, input int budget, output bit ok);
        int b;
        b = 0;
        while (fd_q.size() < n && b < budget) begin tick(); b++; end
        ok = (fd_q.size() >= n);
    endtask

    int last_fd;
    logic [161:0] fa, fb, fc;

    task automatic test_reset();
        reset_n = 1'b0; orient_valid = 1'b0;
        tick(); tick();
        vec++;
        if ({face_start, face_sel, face_orient, latch_active, frame_done, busy} !== 34'd0) begin
            miss++; $display("FAIL reset_outs: got %h want 0",
                {face_start, face_sel, face_orient, latch_active, frame_done, busy});
        end
        vec++;
        if ({pending, drop_count} !== 9'd0) begin
            miss++; $display("FAIL reset_pend: got pending=%b drop=%0d want 0/0", pending, drop_count);
        end
        vec++;
        if ({z_face_start, z_busy, z_pending, z_drop_count, z_face_orient} !== 38'd0) begin
            miss++; $display("FAIL reset_dut0: got nonzero outputs");
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        int n, rd, fdr, lb;
        bit ok;
        do_reset();
        exp_q.delete();
        rd = st_q.size(); fdr = fd_q.size(); lb = latch_n;
        drive_frame(fa, n);
        push_exp(fa, n + 2);
        vec++;
        if (pending !== 1'b1) begin miss++; $display("FAIL single_pend1: got %b want 1", pending); end
        tick();
        vec++;
        if ({face_start, busy, pending} !== 3'b110 || cyc != n + 2) begin
            miss++; $display("FAIL single_first: got start=%b busy=%b pend=%b cyc=%0d want 1/1/0 cyc=%0d",
                face_start, busy, pending, cyc, n + 2);
        end
        wait_starts(rd + NF, 300, ok);
        vec++;
        if (!ok) begin miss++; $display("FAIL single_timeout: got %0d starts want %0d", st_q.size() - rd, NF); end
        else for (int i = 0; i < NF; i++) begin
            ev_t e, o;
            e = exp_q.pop_front(); o = st_q[rd + i];
            vec++;
            if (o.cyc !== e.cyc || o.sel !== e.sel || o.orient !== e.orient) begin
                miss++; $display("FAIL single_start%0d: got cyc=%0d sel=%0d orient=%h want cyc=%0d sel=%0d orient=%h",
                    i, o.cyc, o.sel, o.orient, e.cyc, e.sel, e.orient);
            end
        end
        wait_fd(fdr + 1, 200, ok);
        vec++;
        if (!ok || fd_q[fdr] != n + FRAME_LEN) begin
            miss++; $display("FAIL single_fd: got ok=%b cyc=%0d want cyc=%0d", ok, ok ? fd_q[fdr] : -1, n + FRAME_LEN);
        end
        vec++;
        if (busy !== 1'b0 || latch_n - lb != LC) begin
            miss++; $display("FAIL single_latch: got busy=%b latch=%0d want 0/%0d", busy, latch_n - lb, LC);
        end
        vec++;
        if (drop_count !== 8'd0) begin miss++; $display("FAIL single_drop: got %0d want 0", drop_count); end
        last_fd = n + FRAME_LEN;
    endtask

    task automatic test_refresh();
        int rd, zb;
        bit ok;
        exp_q.delete();
        rd = st_q.size();
        push_exp(fa, last_fd + RC);
        wait_starts(rd + NF, 300, ok);
        vec++;
        if (!ok) begin miss++; $display("FAIL refresh_timeout: got %0d starts want %0d", st_q.size() - rd, NF); end
        else for (int i = 0; i < NF; i++) begin
            ev_t e, o;
            e = exp_q.pop_front(); o = st_q[rd + i];
            vec++;
            if (o.cyc !== e.cyc || o.sel !== e.sel || o.orient !== e.orient) begin
                miss++; $display("FAIL refresh_start%0d: got cyc=%0d sel=%0d orient=%h want cyc=%0d sel=%0d orient=%h",
                    i, o.cyc, o.sel, o.orient, e.cyc, e.sel, e.orient);
            end
        end
        zb = z_starts;
        repeat (1000) tick();
        vec++;
        if (z_starts != zb) begin miss++; $display("FAIL refresh_off: got %0d starts want 0", z_starts - zb); end
    endtask

    task automatic test_back_to_back();
        int n, m, rd;
        bit ok;
        do_reset();
        exp_q.delete();
        rd = st_q.size();
        drive_frame(fa, n);
        push_exp(fa, n + 2);
        push_exp(fb, n + FRAME_LEN + 1);
        wait_starts(rd + 3, 100, ok);
        tick();
        drive_frame(fb, m);
        vec++;
        if (pending !== 1'b1 || busy !== 1'b1) begin
            miss++; $display("FAIL b2b_pend: got pend=%b busy=%b want 1/1", pending, busy);
        end
        wait_starts(rd + 2 * NF, 400, ok);
        vec++;
        if (!ok) begin miss++; $display("FAIL b2b_timeout: got %0d starts want %0d", st_q.size() - rd, 2 * NF); end
        else for (int i = 0; i < 2 * NF; i++) begin
            ev_t e, o;
            e = exp_q.pop_front(); o = st_q[rd + i];
            vec++;
            if (o.cyc !== e.cyc || o.sel !== e.sel || o.orient !== e.orient) begin
                miss++; $display("FAIL b2b_start%0d: got cyc=%0d sel=%0d orient=%h want cyc=%0d sel=%0d orient=%h",
                    i, o.cyc, o.sel, o.orient, e.cyc, e.sel, e.orient);
            end
        end
        vec++;
        if (drop_count !== 8'd0) begin miss++; $display("FAIL b2b_drop: got %0d want 0", drop_count); end
    endtask

    task automatic test_drops();
        int n, m, rd;
        bit ok;
        logic [161:0] f;
        do_reset();
        exp_q.delete();
        rd = st_q.size();
        drive_frame(fa, n);
        push_exp(fa, n + 2);
        push_exp(fc, n + FRAME_LEN + 1);
        wait_starts(rd + 2, 100, ok);
        drive_frame(fb, m);
        drive_frame(mk_frame(27'h0777000), m);
        drive_frame(fc, m);
        vec++;
        if (drop_count !== 8'd2 || pending !== 1'b1) begin
            miss++; $display("FAIL drops_two: got drop=%0d pend=%b want 2/1", drop_count, pending);
        end
        wait_starts(rd + 2 * NF, 400, ok);
        vec++;
        if (!ok) begin miss++; $display("FAIL drops_timeout: got %0d starts want %0d", st_q.size() - rd, 2 * NF); end
        else for (int i = 0; i < 2 * NF; i++) begin
            ev_t e, o;
            e = exp_q.pop_front(); o = st_q[rd + i];
            vec++;
            if (o.cyc !== e.cyc || o.sel !== e.sel || o.orient !== e.orient) begin
                miss++; $display("FAIL drops_start%0d: got cyc=%0d sel=%0d orient=%h want cyc=%0d sel=%0d orient=%h",
                    i, o.cyc, o.sel, o.orient, e.cyc, e.sel, e.orient);
            end
        end
        for (int i = 0; i < 300; i++) begin
            f = mk_frame(27'(32'h100000 + i));
            orient_valid = 1'b1; orient_in = f;
            tick();
        end
        orient_valid = 1'b0;
        vec++;
        if (drop_count !== 8'd255) begin miss++; $display("FAIL drops_sat: got %0d want 255", drop_count); end
    endtask

    task automatic test_spurious();
        int n, rd, fdr, b, fd_exp;
        bit ok;
        ev_t e;
        do_reset();
        exp_q.delete();
        rd = st_q.size(); fdr = fd_q.size();
        drive_frame(fa, n);
        fd_exp = n + FRAME_LEN;
        push_exp(fa, n + 2);
        e.cyc = fd_exp + RC; e.sel = 3'd0; e.orient = fa[26:0];
        exp_q.push_back(e);
        b = 0;
        while (latch_active !== 1'b1 && b < 200) begin tick(); b++; end
        spur = 1'b1; tick(); spur = 1'b0;
        wait_fd(fdr + 1, 100, ok);
        vec++;
        if (!ok || fd_q[fdr] != fd_exp) begin
            miss++; $display("FAIL spur_latch_fd: got ok=%b cyc=%0d want cyc=%0d", ok, ok ? fd_q[fdr] : -1, fd_exp);
        end
        tick(); tick(); tick();
        spur = 1'b1; tick(); spur = 1'b0;
        vec++;
        if (busy !== 1'b0 || face_start !== 1'b0) begin
            miss++; $display("FAIL spur_idle: got busy=%b start=%b want 0/0", busy, face_start);
        end
        wait_starts(rd + NF + 1, 300, ok);
        vec++;
        if (!ok) begin miss++; $display("FAIL spur_timeout: got %0d starts want %0d", st_q.size() - rd, NF + 1); end
        else for (int i = 0; i < NF + 1; i++) begin
            ev_t x, o;
            x = exp_q.pop_front(); o = st_q[rd + i];
            vec++;
            if (o.cyc !== x.cyc || o.sel !== x.sel || o.orient !== x.orient) begin
                miss++; $display("FAIL spur_start%0d: got cyc=%0d sel=%0d orient=%h want cyc=%0d sel=%0d orient=%h",
                    i, o.cyc, o.sel, o.orient, x.cyc, x.sel, x.orient);
            end
        end
        vec++;
        if (fd_q.size() - fdr != 1) begin miss++; $display("FAIL spur_fdcount: got %0d want 1", fd_q.size() - fdr); end
    endtask

    task automatic test_mid_reset();
        int n, m, rd;
        bit ok;
        do_reset();
        exp_q.delete();
        rd = st_q.size();
        drive_frame(fa, n);
        wait_starts(rd + 4, 100, ok);
        tick(); tick();
        vec++;
        if (face_sel !== 3'd3 || busy !== 1'b1) begin
            miss++; $display("FAIL midrst_pre: got sel=%0d busy=%b want 3/1", face_sel, busy);
        end
        reset_n = 1'b0;
        #1;
        vec++;
        if ({face_start, face_sel, face_orient, latch_active, frame_done, busy, pending, drop_count} !== 43'd0) begin
            miss++; $display("FAIL midrst_outs: got %h want 0",
                {face_start, face_sel, face_orient, latch_active, frame_done, busy, pending, drop_count});
        end
        tick();
        reset_n = 1'b1;
        rd = st_q.size();
        repeat (3 * RC) tick();
        vec++;
        if (st_q.size() != rd) begin miss++; $display("FAIL midrst_quiet: got %0d starts want 0", st_q.size() - rd); end
        drive_frame(fb, m);
        push_exp(fb, m + 2);
        wait_starts(rd + 1, 50, ok);
        vec++;
        if (!ok) begin miss++; $display("FAIL midrst_timeout: got 0 starts want 1"); end
        else begin
            ev_t e, o;
            e = exp_q.pop_front(); o = st_q[rd];
            vec++;
            if (o.cyc !== e.cyc || o.sel !== e.sel || o.orient !== e.orient) begin
                miss++; $display("FAIL midrst_start: got cyc=%0d sel=%0d orient=%h want cyc=%0d sel=%0d orient=%h",
                    o.cyc, o.sel, o.orient, e.cyc, e.sel, e.orient);
            end
        end
    endtask

    initial begin
        fa = mk_frame(27'd1);
        fb = mk_frame(27'h5A5A000);
        fc = mk_frame(27'h3C3C100);
        test_reset();
        test_single_frame();
        test_refresh();
        test_back_to_back();
        test_drops();
        test_spurious();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
